// File: rtl/led_cube_ctrl.sv
// led_cube_ctrl: LED cube top-level control FSM with debounced push-buttons.
//   Sequences the datapath through countdown -> position select -> colour select -> animation.
//   Ports:
//     clk, resetn (sync, active-low)
//     key_go_n, key_pause_n, key_back_n : raw active-low asynchronous buttons
//     cda_done     : countdown finished level from the datapath
//     load         : one-cycle pulse on every accepted GO press
//     cda/pos/cho_c/ans : one-hot phase strobes (all low in IDLE)
//     pause        : animation frozen, only high while ans is high
//     state_code   : current state for the HEX display
module led_cube_ctrl #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_go_n,
    input  logic       key_pause_n,
    input  logic       key_back_n,
    input  logic       cda_done,
    output logic       load,
    output logic       cda,
    output logic       pos,
    output logic       cho_c,
    output logic       ans,
    output logic       pause,
    output logic [2:0] state_code
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CDA   = 3'd1,
        POS   = 3'd2,
        COLOR = 3'd3,
        ANIM  = 3'd4
    } state_t;

    // Key vectors are indexed {back, pause, go}; levels are active-high "pressed".
    logic [2:0]       key_n;
    logic [2:0]       sync1_q, sync2_q, stable_q, prev_q, press;
    logic [CNT_W-1:0] cnt_q [3];
    logic             go_p, pause_p, back_p;

    assign key_n   = {key_back_n, key_pause_n, key_go_n};
    assign press   = stable_q & ~prev_q;
    assign go_p    = press[0];
    assign pause_p = press[1];
    assign back_p  = press[2];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
            prev_q  <= stable_q;
            for (int k = 0; k < 3; k++) begin
                // The synchronised level must disagree with the stable level for
                // DEBOUNCE_CYC consecutive cycles before it is accepted.
                if (sync2_q[k] == stable_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    stable_q[k] <= sync2_q[k];
                    cnt_q[k]    <= '0;
                end else begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    state_t state_q, state_d;
    logic   pause_q, pause_d, load_q, cda_q, pos_q, cho_c_q, ans_q;

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && back_p) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = go_p     ? CDA   : IDLE;
                CDA:     state_d = cda_done ? POS   : CDA;
                POS:     state_d = go_p     ? COLOR : POS;
                COLOR:   state_d = go_p     ? ANIM  : COLOR;
                ANIM:    state_d = go_p     ? POS   : ANIM;
                default: state_d = IDLE;
            endcase
        end
        // Pause only survives while staying in ANIM; entering or leaving clears it.
        pause_d = (state_q == ANIM && state_d == ANIM) ? pause_q ^ pause_p : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            pause_q <= 1'b0;
            load_q  <= 1'b0;
            cda_q   <= 1'b0;
            pos_q   <= 1'b0;
            cho_c_q <= 1'b0;
            ans_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            load_q  <= go_p;
            cda_q   <= state_d == CDA;
            pos_q   <= state_d == POS;
            cho_c_q <= state_d == COLOR;
            ans_q   <= state_d == ANIM;
        end
    end

    assign load       = load_q;
    assign cda        = cda_q;
    assign pos        = pos_q;
    assign cho_c      = cho_c_q;
    assign ans        = ans_q;
    assign pause      = pause_q;
    assign state_code = state_q;
endmodule

// File: tb/tb_led_cube_ctrl.sv
// tb_led_cube_ctrl: directed and randomized checks of led_cube_ctrl against a behavioural model.
module tb_led_cube_ctrl;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_go_n = 1'b1, key_pause_n = 1'b1, key_back_n = 1'b1;
    logic       cda_done = 1'b0;
    logic       load, cda, pos, cho_c, ans, pause;
    logic [2:0] state_code;

    int total = 0;
    int bad   = 0;

    led_cube_ctrl #(.DEBOUNCE_CYC(DC)) dut (
        .clk(clk), .resetn(resetn),
        .key_go_n(key_go_n), .key_pause_n(key_pause_n), .key_back_n(key_back_n),
        .cda_done(cda_done),
        .load(load), .cda(cda), .pos(pos), .cho_c(cho_c), .ans(ans), .pause(pause),
        .state_code(state_code)
    );

    always #5 clk = ~clk;

    // Reference model: phase number 0..4, pause flag, load flag, and per-key
    // raw-press history. A key's debounced level flips once the last DC
    // synchronised samples (raw delayed by two cycles) all disagree with it.
    int          m_state = 0;
    logic        m_pause = 1'b0, m_load = 1'b0;
    logic [15:0] hist [3];
    logic [2:0]  st = '0, pv = '0;
    int          ns;
    logic [2:0]  p, raw;

    initial for (int k = 0; k < 3; k++) hist[k] = '0;

    always @(posedge clk) begin
        raw = {~key_back_n, ~key_pause_n, ~key_go_n};
        if (!resetn) begin
            m_state = 0;
            m_pause = 1'b0;
            m_load  = 1'b0;
            st      = '0;
            pv      = '0;
            for (int k = 0; k < 3; k++) hist[k] = '0;
        end else begin
            p      = st & ~pv;
            m_load = p[0];
            ns     = m_state;
            if (m_state != 0 && p[2]) ns = 0;
            else if (m_state == 0 && p[0]) ns = 1;
            else if (m_state == 1 && cda_done) ns = 2;
            else if (m_state == 2 && p[0]) ns = 3;
            else if (m_state == 3 && p[0]) ns = 4;
            else if (m_state == 4 && p[0]) ns = 2;
            m_pause = (m_state == 4 && ns == 4) ? (m_pause ^ p[1]) : 1'b0;
            m_state = ns;
            pv = st;
            for (int k = 0; k < 3; k++) begin
                hist[k] = {hist[k][14:0], raw[k]};
                if (hist[k][DC+1:2] == (st[k] ? 4'b0000 : 4'b1111)) st[k] = ~st[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("load", {7'd0, load}, {7'd0, m_load});
        chk("cda", {7'd0, cda}, {7'd0, m_state == 1});
        chk("pos", {7'd0, pos}, {7'd0, m_state == 2});
        chk("cho_c", {7'd0, cho_c}, {7'd0, m_state == 3});
        chk("ans", {7'd0, ans}, {7'd0, m_state == 4});
        chk("pause", {7'd0, pause}, {7'd0, m_pause});
        chk("state_code", {5'd0, state_code}, 8'(m_state));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            chk_model();
        end
    endtask

    task automatic press_go();
        key_go_n = 1'b0;
        cyc(6);
        key_go_n = 1'b1;
        cyc(8);
    endtask

    task automatic press_pause();
        key_pause_n = 1'b0;
        cyc(6);
        key_pause_n = 1'b1;
        cyc(8);
    endtask

    task automatic chk_outs(input string tag, input logic [8:0] exp);
        chk(tag, {load, cda, pos, cho_c, ans, pause, state_code}, exp);
    endtask

    initial begin
        // 1. Reset, then idle with keys released.
        repeat (3) @(negedge clk);
        chk_outs("reset_all_zero", 9'd0);
        resetn = 1'b1;
        cyc(20);
        chk_outs("idle_after_20", 9'd0);

        // 2. GO press accepted after 2 + DC cycles, load one cycle later.
        key_go_n = 1'b0;
        cyc(6);
        chk("go_load_early", {7'd0, load}, 8'd0);
        cyc(1);
        chk("go_load_at_7", {7'd0, load}, 8'd1);
        chk("go_cda", {7'd0, cda}, 8'd1);
        chk("go_state_cda", {5'd0, state_code}, 8'd1);
        cyc(1);
        chk("go_load_single", {7'd0, load}, 8'd0);
        cyc(2);
        key_go_n = 1'b1;
        cyc(10);
        key_go_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) key_go_n = 1'b1;
            cyc(1);
            chk("glitch_no_load", {7'd0, load}, 8'd0);
        end

        // 3. CDA ignores GO, leaves on cda_done, then GO walks to ANIM.
        press_go();
        chk("cda_ignores_go", {5'd0, state_code}, 8'd1);
        cda_done = 1'b1;
        cyc(1);
        cda_done = 1'b0;
        chk("cda_done_pos", {7'd0, pos}, 8'd1);
        chk("cda_done_state", {5'd0, state_code}, 8'd2);
        press_go();
        chk("pos_to_color", {5'd0, state_code}, 8'd3);
        chk("color_strobe", {7'd0, cho_c}, 8'd1);
        press_go();
        chk("color_to_anim", {5'd0, state_code}, 8'd4);
        chk("anim_strobe", {7'd0, ans}, 8'd1);

        // 4. Pause toggling and GO reselect.
        press_pause();
        chk("pause_on", {7'd0, pause}, 8'd1);
        press_pause();
        chk("pause_off", {7'd0, pause}, 8'd0);
        press_pause();
        press_go();
        chk_outs("pause_go_pos", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2});

        // 5. Simultaneous GO and PAUSE while paused: GO wins, pause cleared.
        press_go();
        press_go();
        press_pause();
        chk("paused_again", {7'd0, pause}, 8'd1);
        key_go_n    = 1'b0;
        key_pause_n = 1'b0;
        cyc(6);
        key_go_n    = 1'b1;
        key_pause_n = 1'b1;
        cyc(8);
        chk_outs("go_pause_same", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2});

        // 6. BACK + GO together in COLOR returns to IDLE; reset mid-ANIM.
        press_go();
        chk("in_color", {5'd0, state_code}, 8'd3);
        key_go_n   = 1'b0;
        key_back_n = 1'b0;
        cyc(6);
        key_go_n   = 1'b1;
        key_back_n = 1'b1;
        cyc(8);
        chk_outs("back_idle", 9'd0);
        press_go();
        cda_done = 1'b1;
        cyc(1);
        cda_done = 1'b0;
        press_go();
        press_go();
        press_pause();
        chk("anim_before_reset", {5'd0, state_code}, 8'd4);
        resetn = 1'b0;
        cyc(1);
        chk_outs("reset_mid_anim", 9'd0);
        resetn = 1'b1;
        cyc(3);

        // Randomized phase checked every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) key_go_n = ~key_go_n;
            if ($urandom_range(0, 11) == 0) key_pause_n = ~key_pause_n;
            if ($urandom_range(0, 39) == 0) key_back_n = ~key_back_n;
            cda_done = ($urandom_range(0, 7) == 0);
            resetn   = ($urandom_range(0, 599) != 0);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
